// File: rtl/emu_reset_seq.sv
// emu_reset_seq: releases NUM_STAGES reset domains one at a time, each after its predecessor reports ready.
// Rev 1.0 - initial release.
`default_nettype none

module emu_reset_seq #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic [NUM_STAGES-1:0] ready,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_STAGES-1:0] err
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic            ready_now;

  assign ready_now = ready[idx];

  // Stages fall strictly in index order, so each release is a left shift of the reset vector.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_HOLD;
      idx         <= '0;
      cnt         <= '0;
      stage_reset <= '1;
      busy        <= 1'b1;
      done        <= 1'b0;
      err         <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state       <= ST_WAIT;
            idx         <= '0;
            cnt         <= '0;
            stage_reset <= ~NUM_STAGES'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_WAIT: begin
          // A ready seen on the timeout edge counts as success.
          if (ready_now || (cnt == TMO_LAST)) begin
            if (!ready_now) begin
              err <= err | (NUM_STAGES'(1) << idx);
            end
            cnt <= '0;
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              idx         <= idx + IW'(1);
              stage_reset <= stage_reset << 1;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state       <= ST_WAIT;
            idx         <= idx + IW'(1);
            cnt         <= '0;
            stage_reset <= stage_reset << 1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DONE: begin
          if (req) begin
            state       <= ST_HOLD;
            idx         <= '0;
            cnt         <= '0;
            stage_reset <= '1;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= '0;
          end
        end

        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
